// File: rtl/aes_key_sched_ctrl.sv
// Sequencer in front of aes_key_gen: walks it through an AES-128 key expansion
// and buffers the NR+1 round keys behind a registered read port.
module aes_key_sched_ctrl #(
  parameter int KG_LAT = 2,
  parameter int NR     = 10
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  output logic         kg_en,
  output logic         kg_gen_key,
  output logic         kg_next_rnd,
  output logic [127:0] kg_key_i,
  output logic [7:0]   kg_r_con,
  input  logic [127:0] kg_key_o,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WAIT  = 3'd2,
    S_STORE = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(KG_LAT);
  localparam logic [3:0] RND_LAST = 4'(NR);

  state_t       r_state;
  state_t       w_state_nxt;
  logic         w_accept;
  logic [127:0] r_key;
  logic [127:0] r_rk [0:NR];
  logic [127:0] r_rk_data;
  logic [3:0]   r_rnd;
  logic [3:0]   r_wait;
  logic [7:0]   r_rcon;
  logic         r_busy;
  logic         r_done;
  logic         r_keys_valid;
  logic         r_gen_key;
  logic         r_next_rnd;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  assign w_accept = (r_state == S_IDLE) && start;

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; WAIT exits on the cycle its counter hits zero
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_LOAD;
        else       w_state_nxt = S_IDLE;
      end
      S_LOAD: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (r_wait <= 4'd1) w_state_nxt = S_STORE;
        else                w_state_nxt = S_WAIT;
      end
      S_STORE: begin
        if (r_rnd == RND_LAST) w_state_nxt = S_DONE;
        else                   w_state_nxt = S_NEXT;
      end
      S_NEXT:  w_state_nxt = S_WAIT;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control outputs registered from the next state so they line up with it;
  // done/keys_valid are set as DONE is left
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_busy       <= 1'b0;
      r_gen_key    <= 1'b0;
      r_next_rnd   <= 1'b0;
      r_done       <= 1'b0;
      r_keys_valid <= 1'b0;
    end else begin
      r_busy     <= (w_state_nxt != S_IDLE);
      r_gen_key  <= (w_state_nxt == S_LOAD);
      r_next_rnd <= (w_state_nxt == S_NEXT);
      r_done     <= (r_state == S_DONE);
      if (w_accept) begin
        r_keys_valid <= 1'b0;
      end else if (r_state == S_DONE) begin
        r_keys_valid <= 1'b1;
      end else begin
        r_keys_valid <= r_keys_valid;
      end
    end
  end

  // Key latch, round counter, round constant and wait counter
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_key  <= 128'h0;
      r_rnd  <= 4'd0;
      r_rcon <= 8'h01;
      r_wait <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_key  <= key_in;
            r_rnd  <= 4'd1;
            r_rcon <= 8'h01;
          end
        end
        S_LOAD, S_NEXT: r_wait <= LAT_INIT;
        S_WAIT:         r_wait <= r_wait - 4'd1;
        S_STORE: begin
          if (r_rnd != RND_LAST) begin
            r_rnd  <= r_rnd + 4'd1;
            r_rcon <= xtime(r_rcon);
          end
        end
        default: r_wait <= r_wait;
      endcase
    end
  end

  // Round-key buffer; the read sees the pre-write contents on a same-edge STORE
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i <= NR; i++) begin
        r_rk[i] <= 128'h0;
      end
      r_rk_data <= 128'h0;
    end else begin
      if (w_accept) begin
        r_rk[0] <= key_in;
      end else if (r_state == S_STORE) begin
        r_rk[r_rnd] <= kg_key_o;
      end
      r_rk_data <= (rk_addr <= RND_LAST) ? r_rk[rk_addr] : 128'h0;
    end
  end

  assign busy        = r_busy;
  assign kg_en       = r_busy;
  assign done        = r_done;
  assign keys_valid  = r_keys_valid;
  assign kg_gen_key  = r_gen_key;
  assign kg_next_rnd = r_next_rnd;
  assign kg_key_i    = r_key;
  assign kg_r_con    = r_busy ? r_rcon : 8'h00;
  assign rk_data     = r_rk_data;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: two builds (KG_LAT=2 and KG_LAT=1) share the
// stimulus, each driven by its own behavioural aes_key_gen model.
module tb_aes_key_sched_ctrl;

  localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RK10_A = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = 128'h0;
  logic [3:0]   rk_addr = 4'd0;

  logic         a_busy, a_done, a_kv, a_en, a_gen, a_next;
  logic [127:0] a_key_i, a_key_o, a_rk_data;
  logic [7:0]   a_rcon;
  logic         b_busy, b_done, b_kv, b_en, b_gen, b_next;
  logic [127:0] b_key_i, b_key_o, b_rk_data;
  logic [7:0]   b_rcon;

  int checks = 0;
  int errors = 0;

  aes_key_sched_ctrl #(.KG_LAT(2), .NR(10)) u_dut_a (
    .clk(clk), .nrst(nrst), .start(start), .key_in(key_in),
    .busy(a_busy), .done(a_done), .keys_valid(a_kv), .kg_en(a_en),
    .kg_gen_key(a_gen), .kg_next_rnd(a_next), .kg_key_i(a_key_i),
    .kg_r_con(a_rcon), .kg_key_o(a_key_o), .rk_addr(rk_addr), .rk_data(a_rk_data));

  aes_key_sched_ctrl #(.KG_LAT(1), .NR(10)) u_dut_b (
    .clk(clk), .nrst(nrst), .start(start), .key_in(key_in),
    .busy(b_busy), .done(b_done), .keys_valid(b_kv), .kg_en(b_en),
    .kg_gen_key(b_gen), .kg_next_rnd(b_next), .kg_key_i(b_key_i),
    .kg_r_con(b_rcon), .kg_key_o(b_key_o), .rk_addr(rk_addr), .rk_data(b_rk_data));

  always #5 clk = ~clk;

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] kround(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sb(k[23:16]), sb(k[15:8]), sb(k[7:0]), sb(k[31:24])} ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] rk_of(input logic [127:0] k, input int r);
    logic [127:0] kk;
    logic [7:0]   rc;
    kk = k;
    rc = 8'h01;
    for (int i = 0; i < r; i++) begin
      kk = kround(kk, rc);
      rc = xt(rc);
    end
    return kk;
  endfunction

  // Key generator models: result valid only in the cycle KG_LAT edges after the
  // pulse edge, inverted garbage otherwise, so mistimed sampling corrupts keys
  logic [127:0] ma_key, mb_key;
  int           ma_cnt, mb_cnt;
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ma_cnt <= -1; ma_key <= 128'h0;
    end else if (a_gen) begin
      ma_key <= kround(a_key_i, a_rcon); ma_cnt <= 2;
    end else if (a_next) begin
      ma_key <= kround(ma_key, a_rcon); ma_cnt <= 2;
    end else if (ma_cnt >= 0) begin
      ma_cnt <= ma_cnt - 1;
    end
  end
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mb_cnt <= -1; mb_key <= 128'h0;
    end else if (b_gen) begin
      mb_key <= kround(b_key_i, b_rcon); mb_cnt <= 1;
    end else if (b_next) begin
      mb_key <= kround(mb_key, b_rcon); mb_cnt <= 1;
    end else if (mb_cnt >= 0) begin
      mb_cnt <= mb_cnt - 1;
    end
  end
  assign a_key_o = (ma_cnt == 0) ? ma_key : ~ma_key;
  assign b_key_o = (mb_cnt == 0) ? mb_key : ~mb_key;

  logic [7:0] q_rcon[$];
  int n_gen_a = 0, n_next_a = 0, n_gen_b = 0, n_next_b = 0, n_overlap = 0;
  always @(negedge clk) begin
    if (nrst) begin
      if (a_gen || a_next) q_rcon.push_back(a_rcon);
      if (a_gen) n_gen_a++;
      if (a_next) n_next_a++;
      if (b_gen) n_gen_b++;
      if (b_next) n_next_b++;
      if ((a_gen && a_next) || (b_gen && b_next)) n_overlap++;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl_a"}, 128'({a_busy, a_done, a_kv, a_en, a_gen, a_next}), 128'h0);
    chk({tag, "_ctl_b"}, 128'({b_busy, b_done, b_kv, b_en, b_gen, b_next}), 128'h0);
    chk({tag, "_key_i"}, a_key_i, 128'h0);
    chk({tag, "_rcon"}, 128'({a_rcon, b_rcon}), 128'h0);
    chk({tag, "_rk_data"}, a_rk_data | b_rk_data, 128'h0);
  endtask

  // Starts an expansion and runs 60 edges, recording when each build's done appears
  task automatic run_exp(input logic [127:0] key, input bit spur,
                         output int d_a, output int d_b, output bit kv_early);
    @(posedge clk); #1;
    start = 1'b1; key_in = key;
    @(posedge clk); #1;
    start = 1'b0;
    d_a = -1; d_b = -1; kv_early = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      if (spur && n == 10) begin start = 1'b1; key_in = KEY_B; end
      if (spur && n == 11) start = 1'b0;
      @(posedge clk); #1;
      if (a_done && d_a < 0) d_a = n;
      if (b_done && d_b < 0) d_b = n;
      if (a_kv && d_a < 0) kv_early = 1'b1;
      if (spur && n == 12) chk("key_i_held", a_key_i, key);
    end
  endtask

  typedef struct {
    logic [3:0]   addr;
    logic [127:0] exp;
  } rd_vec_t;

  rd_vec_t    rd_tab [13];
  logic [7:0] rcon_tab [10];
  int         d_a, d_b, base;
  bit         kv_early;
  int         g_a0, x_a0, g_b0, x_b0;

  initial begin
    rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    rd_tab[0] = '{4'd0, KEY_A};
    for (int i = 1; i < 10; i++) rd_tab[i] = '{4'(i), rk_of(KEY_A, i)};
    rd_tab[10] = '{4'd10, RK10_A};
    rd_tab[11] = '{4'd11, 128'h0};
    rd_tab[12] = '{4'd15, 128'h0};

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    nrst = 1'b1;

    // Expansion of KEY_A with a stray start at edge 10
    base = q_rcon.size();
    g_a0 = n_gen_a; x_a0 = n_next_a; g_b0 = n_gen_b; x_b0 = n_next_b;
    run_exp(KEY_A, 1'b1, d_a, d_b, kv_early);
    chk("done_edge_lat2", 128'(d_a), 128'd41);
    chk("done_edge_lat1", 128'(d_b), 128'd31);
    chk("keys_valid_a", 128'(a_kv), 128'd1);
    chk("keys_valid_b", 128'(b_kv), 128'd1);
    chk("busy_after", 128'({a_busy, b_busy}), 128'd0);
    chk("rcon_count", 128'(q_rcon.size() - base), 128'd10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("rcon_%0d", i), 128'((base + i < q_rcon.size()) ? q_rcon[base + i] : 8'h00),
          128'(rcon_tab[i]));
    end
    chk("gen_pulses_a", 128'(n_gen_a - g_a0), 128'd1);
    chk("next_pulses_a", 128'(n_next_a - x_a0), 128'd9);
    chk("gen_pulses_b", 128'(n_gen_b - g_b0), 128'd1);
    chk("next_pulses_b", 128'(n_next_b - x_b0), 128'd9);
    chk("pulse_overlap", 128'(n_overlap), 128'd0);

    // Read-port sweep: old data just before the edge, new data after it
    for (int i = 0; i < 13; i++) begin
      rk_addr = rd_tab[i].addr;
      #1;
      if (i > 0) chk($sformatf("rd_hold_%0d", rd_tab[i].addr), a_rk_data, rd_tab[i-1].exp);
      @(posedge clk); #1;
      chk($sformatf("rd_a_%0d", rd_tab[i].addr), a_rk_data, rd_tab[i].exp);
      chk($sformatf("rd_b_%0d", rd_tab[i].addr), b_rk_data, rd_tab[i].exp);
    end

    // Start during DONE is dropped, start the next cycle is taken
    @(posedge clk); #1;
    start = 1'b1; key_in = KEY_B;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("pre_done", 128'({a_busy, a_done}), 128'b10);
    start = 1'b1; key_in = KEY_C;
    @(posedge clk); #1;
    chk("done_cycle_start", 128'({a_done, a_busy, a_kv}), 128'b101);
    @(posedge clk); #1;
    start = 1'b0;
    chk("idle_start", 128'({a_busy, a_kv}), 128'b10);
    chk("idle_start_key", a_key_i, KEY_C);

    // Asynchronous reset at edge 20 of that expansion
    repeat (20) @(posedge clk);
    #1;
    chk("pre_reset_busy", 128'(a_busy), 128'd1);
    nrst = 1'b0;
    #1;
    check_zero("midrst");
    #2;
    nrst = 1'b1;

    run_exp(KEY_C, 1'b0, d_a, d_b, kv_early);
    chk("rerun_done_lat2", 128'(d_a), 128'd41);
    chk("rerun_done_lat1", 128'(d_b), 128'd31);
    chk("rerun_kv_early", 128'(kv_early), 128'd0);
    chk("rerun_kv", 128'({a_kv, b_kv}), 128'b11);
    rk_addr = 4'd10;
    @(posedge clk); #1;
    chk("rerun_rk10_a", a_rk_data, rk_of(KEY_C, 10));
    chk("rerun_rk10_b", b_rk_data, rk_of(KEY_C, 10));
    rk_addr = 4'd5;
    @(posedge clk); #1;
    chk("rerun_rk5_a", a_rk_data, rk_of(KEY_C, 5));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
- Sequencing stage directly upstream of aes_key_gen.
- On a start request it latches the 128-bit cipher key and drives aes_key_gen's control inputs: gen_key, next_rnd, en, key_i and r_con_i.
- It generates the round-constant sequence and captures each key_o result into an 11-entry round-key buffer.
- The cipher datapath reads round keys from the buffer through a registered read port.

Parameters:
- KG_LAT, 2, cycles to wait after gen_key/next_rnd before sampling kg_key_o; legal range 1..15.
- NR, 10, number of expansion rounds (AES-128); buffer depth is NR+1.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to expand key_in; ignored unless state is IDLE.
- key_in  in  128  cipher key, sampled on the edge where start is accepted.
- busy  out  1  high from the accepting edge until DONE exits.
- done  out  1  one-cycle pulse when all NR+1 round keys are stored.
- keys_valid  out  1  level; high from done until the next accepted start or reset.
- kg_en  out  1  drives aes_key_gen en; equals busy.
- kg_gen_key  out  1  drives gen_key; high only in LOAD.
- kg_next_rnd  out  1  drives next_rnd; high only in NEXT.
- kg_key_i  out  128  drives key_i; latched key, stable while busy.
- kg_r_con  out  8  drives r_con_i; current round constant.
- kg_key_o  in  128  round key returned by aes_key_gen.
- rk_addr  in  4  round-key read index 0..NR.
- rk_data  out  128  registered read data.

Behaviour:
- Reset (nrst low, asynchronous):
  - state=IDLE; all outputs 0.
  - round counter=0; rcon=8'h01; buffer entries cleared to 0.
- Reset asserted mid-expansion aborts immediately; keys_valid stays 0 until a full new expansion completes.
- States and transitions:
  - IDLE: start=1 -> latch key_in into kg_key_i and rk[0]; rnd=1; rcon=01; keys_valid<=0; go to LOAD.
  - LOAD (1 cycle): kg_gen_key=1; wait counter=KG_LAT; go to WAIT.
  - WAIT (KG_LAT cycles): decrement counter; when it reaches 0 go to STORE.
  - STORE (1 cycle): rk[rnd]<=kg_key_o.
    - If rnd==NR go to DONE.
    - Else rnd<=rnd+1, rcon<=xtime(rcon), go to NEXT.
  - NEXT (1 cycle): kg_next_rnd=1; counter=KG_LAT; go to WAIT.
  - DONE (1 cycle): done=1; keys_valid<=1; go to IDLE.
- xtime(r) = {r[6:0],1'b0} XOR (r[7] ? 8'h1B : 8'h00).
  - Sequence: 01,02,04,08,10,20,40,80,1B,36.
  - kg_r_con holds the value for round rnd throughout that round's NEXT/WAIT/STORE.
- Latency: done is high in the cycle beginning 10*KG_LAT+21 edges after the start-sampling edge (41 for KG_LAT=2, NR=10).
- start while busy: ignored; no restart, no effect on the latched key.
- start in the DONE cycle: ignored. start in IDLE the cycle after DONE: accepted.
- Read port:
  - rk_data<=rk[rk_addr] on every rising edge, so read latency is 1 cycle.
  - rk_addr>NR returns 0.
  - Reads are allowed while busy; unwritten entries return stale or reset data.
- Same-cycle STORE write and read of the same index: rk_data returns the old value (read-before-write).
- kg_gen_key and kg_next_rnd are never high simultaneously, and neither is high outside LOAD/NEXT.

Test Plan:
- Reset, then start with key_in=128'h2b7e151628aed2a6abf7158809cf4f3c and a model key_gen -> done pulses at edge 41 after start.
  - rk[10] reads 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 and rk[0] equals the key.
  - keys_valid=1.
- Monitor kg_r_con at each kg_next_rnd pulse -> 02,04,08,10,20,40,80,1B,36 in order; 01 during LOAD.
- Pulse start again at edge 10 of an expansion with a different key_in -> no effect.
  - kg_key_i unchanged; done still at edge 41; results match the first key.
- Drop nrst at edge 20 of an expansion -> all outputs 0 immediately.
  - A new start then completes normally with keys_valid only after the new done.
- After completion read rk_addr=0..10 then 11,15 -> data appears 1 cycle after each address; addresses 11 and 15 return 0.
- KG_LAT=1 build -> done at edge 31.
  - Exactly one kg_gen_key pulse and 9 kg_next_rnd pulses; each kg_key_o is sampled exactly KG_LAT cycles after its pulse.
